dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory RAM (dmem_ram) between two requesters: the core LSU and a debug/loader port.
//  The debug/loader port is used for preload and dump of data memory in hardware.
//  Sits between the core pipeline and the data memory instance inside the memory subsystem.
//  Core has priority; an anti-starvation counter bounds debug wait.
//  A lock mode gives the debug port exclusive bursts.
// PARAMETERS
//  ADDR_W      32   byte address width on both requester ports
//  DATA_W      32   data width; byte enables are DATA_W/8 bits
//  STARVE_MAX  8    max consecutive core grants while debug is pending before debug is forced a slot (1..255)
// PORTS
//  clk          in   1         single clock; all logic on rising edge
//  rst_n        in   1         reset, synchronous, active-low
//  core_req     in   1         core memory request
//  core_we      in   1         1=write, 0=read
//  core_addr    in   ADDR_W    byte address
//  core_wdata   in   DATA_W    write data
//  core_be      in   DATA_W/8  byte enables
//  core_gnt     out  1         request accepted this cycle
//  core_rvalid  out  1         read data valid (1 cycle after granted read)
//  core_rdata   out  DATA_W    read data
//  dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_be/dbg_gnt/dbg_rvalid/dbg_rdata  same as core_*, debug side
//  dbg_lock     in   1         debug requests exclusive ownership
//  dbg_owned    out  1         exclusive ownership currently held by debug
//  mem_en       out  1         RAM access strobe
//  mem_we/mem_addr/mem_wdata/mem_be  out  to RAM, driven by winner
//  mem_rdata    in   DATA_W    RAM read data, valid 1 cycle after mem_en&&!mem_we
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - state=ARB, starve_cnt=0, rd_owner=NONE.
//   - core_rvalid=dbg_rvalid=0, dbg_owned=0.
//   - rdata outputs=0.
//   - A read granted in the reset cycle never returns rvalid.
//  Grants are combinational from req+state; at most one gnt per cycle.
//   - mem_en = core_gnt|dbg_gnt.
//   - mem_* mux follows the winner; mem_* = 0 when idle.
//  Handshake: a request completes on req&&gnt. Requester holds fields stable until gnt. No outstanding-limit: one access per cycle.
//  FSM:
//   ARB:
//    - core_req wins, unless dbg_req && starve_cnt==STARVE_MAX, in which case dbg wins.
//    - Otherwise dbg wins if core_req=0.
//    - starve_cnt increments (saturating) when core is granted while dbg_req=1.
//    - starve_cnt clears when dbg is granted or dbg_req=0.
//    - ARB->LOCK when dbg_lock=1 and no core grant this cycle; dbg may be granted in that same cycle.
//   LOCK:
//    - dbg_owned=1; core_gnt=0; dbg_gnt=dbg_req.
//    - LOCK->ARB when dbg_lock=0; core eligible the next cycle. starve_cnt=0 on exit.
//  Read return:
//   - rd_owner is registered from the granted read.
//   - Next cycle: owner's rvalid=1 and owner's rdata=mem_rdata. Other side: rvalid=0, rdata holds its last value.
//   - Writes produce no rvalid.
//  Back-to-back: a new grant in the same cycle as an rvalid return is legal; rd_owner updates every cycle.
//  Simultaneous events:
//   - dbg_lock rising while core_req=1 in ARB: core served first.
//   - LOCK is entered on the first cycle with no core grant. Worst case is bounded by STARVE_MAX+1 cycles, because the dbg request is pending.
// STRUCTURE
//  Package dmem_arb_pkg:
//   - typedef enum {ARB,LOCK} arb_state_e
//   - typedef enum {NONE,CORE,DBG} rd_owner_e
//   - typedef struct mem_req_t {we,addr,wdata,be}
//  Single module, no sub-modules.
//  Registers: state, starve_cnt, rd_owner, core_rdata, dbg_rdata.
// TESTING
//  1. Reset, then core read addr 0x10 (RAM=0xDEADBEEF) -> core_gnt same cycle; core_rvalid=1, core_rdata=0xDEADBEEF next cycle; dbg_rvalid=0.
//  2. core_req and dbg_req both held 20 cycles, STARVE_MAX=8 -> 8 core grants, then 1 dbg grant, repeating; never 2 gnts in one cycle.
//  3. dbg_lock=1 with core_req=1 in ARB -> core granted once, then dbg_owned=1, core_gnt=0 for all LOCK cycles; release dbg_lock -> core granted next cycle.
//  4. Debug writes 0x12345678 (be=4'b1111) to 0x40 in LOCK, then core reads 0x40 -> core_rdata=0x12345678; byte write be=4'b0010 of 0xAB00 -> 0x1234AB78.
//  5. rst_n=0 asserted the cycle after a granted dbg read -> dbg_rvalid=0, state=ARB, dbg_owned=0, starve_cnt=0.
//  6. Alternating core read / dbg read each cycle -> each rvalid goes only to the correct owner with the correct data.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arb_pkg: shared types for the data-memory port arbiter                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_BE_W   = DMEM_DATA_W / 8;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    DBG  = 2'd2
  } rd_owner_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [DMEM_BE_W-1:0]   be;
  } mem_req_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_port_arbiter: core/debug arbiter for the single-port data memory RAM  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_req_i,
  input  logic                core_we_i,
  input  logic [ADDR_W-1:0]   core_addr_i,
  input  logic [DATA_W-1:0]   core_wdata_i,
  input  logic [DATA_W/8-1:0] core_be_i,
  output logic                core_gnt_o,
  output logic                core_rvalid_o,
  output logic [DATA_W-1:0]   core_rdata_o,
  input  logic                dbg_req_i,
  input  logic                dbg_we_i,
  input  logic [ADDR_W-1:0]   dbg_addr_i,
  input  logic [DATA_W-1:0]   dbg_wdata_i,
  input  logic [DATA_W/8-1:0] dbg_be_i,
  output logic                dbg_gnt_o,
  output logic                dbg_rvalid_o,
  output logic [DATA_W-1:0]   dbg_rdata_o,
  input  logic                dbg_lock_i,
  output logic                dbg_owned_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam logic [7:0] c_starve_max = 8'(STARVE_MAX);

  arb_state_e      state_q, state_d;
  logic [7:0]      starve_cnt_q, starve_cnt_d;
  rd_owner_e       rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic     w_core_gnt;
  logic     w_dbg_gnt;
  mem_req_t w_mem;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB;
      starve_cnt_q <= '0;
      rd_owner_q   <= NONE;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Output logic: grants and ownership
  always_comb begin
    w_core_gnt  = 1'b0;
    w_dbg_gnt   = 1'b0;
    dbg_owned_o = 1'b0;
    case (state_q)
      ARB: begin
        w_core_gnt = core_req_i && !(dbg_req_i && (starve_cnt_q == c_starve_max));
        w_dbg_gnt  = dbg_req_i && !w_core_gnt;
      end
      LOCK: begin
        dbg_owned_o = 1'b1;
        w_dbg_gnt   = dbg_req_i;
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      ARB: begin
        if (w_core_gnt && dbg_req_i) begin
          starve_cnt_d = sat_inc(starve_cnt_q, c_starve_max);
        end else if (w_dbg_gnt || !dbg_req_i) begin
          starve_cnt_d = '0;
        end
        if (dbg_lock_i && !w_core_gnt) begin
          state_d = LOCK;
        end
      end
      LOCK: begin
        starve_cnt_d = '0;
        if (!dbg_lock_i) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Read-return bookkeeping: a side's rdata tracks the RAM only while it owns the return
  always_comb begin
    rd_owner_d = NONE;
    if (w_core_gnt && !core_we_i) begin
      rd_owner_d = CORE;
    end else if (w_dbg_gnt && !dbg_we_i) begin
      rd_owner_d = DBG;
    end
    core_rdata_d = (rd_owner_q == CORE) ? mem_rdata_i : core_rdata_q;
    dbg_rdata_d  = (rd_owner_q == DBG)  ? mem_rdata_i : dbg_rdata_q;
  end

  always_comb begin
    w_mem = '0;
    if (w_core_gnt) begin
      w_mem = '{we: core_we_i, addr: core_addr_i, wdata: core_wdata_i, be: core_be_i};
    end else if (w_dbg_gnt) begin
      w_mem = '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i, be: dbg_be_i};
    end
  end

  assign core_gnt_o    = w_core_gnt;
  assign dbg_gnt_o     = w_dbg_gnt;
  assign core_rvalid_o = (rd_owner_q == CORE);
  assign dbg_rvalid_o  = (rd_owner_q == DBG);
  assign core_rdata_o  = core_rdata_d;
  assign dbg_rdata_o   = dbg_rdata_d;
  assign mem_en_o      = w_core_gnt | w_dbg_gnt;
  assign mem_we_o      = w_mem.we;
  assign mem_addr_o    = w_mem.addr;
  assign mem_wdata_o   = w_mem.wdata;
  assign mem_be_o      = w_mem.be;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_port_arbiter: directed self-checking bench with a behavioural RAM  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic [3:0]  core_be, dbg_be;
  logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid, dbg_owned;
  logic [31:0] core_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [31:0] ram [0:255];
  int          n_checks = 0;
  int          n_errors = 0;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_be_i(core_be), .core_gnt_o(core_gnt),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_be_i(dbg_be), .dbg_gnt_o(dbg_gnt),
    .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .dbg_lock_i(dbg_lock), .dbg_owned_o(dbg_owned),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[9:2]];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_be = '0;
    dbg_req  = 0; dbg_we  = 0; dbg_addr  = '0; dbg_wdata  = '0; dbg_be  = '0;
  endtask

  task automatic core_rd(input logic [31:0] a);
    core_req = 1; core_we = 0; core_addr = a; core_be = 4'hF;
  endtask

  task automatic dbg_rd(input logic [31:0] a);
    dbg_req = 1; dbg_we = 0; dbg_addr = a; dbg_be = 4'hF;
  endtask

  task automatic dbg_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    dbg_req = 1; dbg_we = 1; dbg_addr = a; dbg_wdata = d; dbg_be = be;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    mem_rdata = '0;
    ram[8'h04] = 32'hDEADBEEF;
    for (int i = 0; i < 6; i++) ram[8 + i] = 32'hA000_0000 + i;
    idle();
    dbg_lock = 0;
    rst_n    = 0;
    step(); step();

    // Reset state
    check_eq("rst_core_rvalid", 32'(core_rvalid), 0);
    check_eq("rst_dbg_rvalid",  32'(dbg_rvalid), 0);
    check_eq("rst_core_rdata",  core_rdata, 0);
    check_eq("rst_dbg_rdata",   dbg_rdata, 0);
    check_eq("rst_dbg_owned",   32'(dbg_owned), 0);
    check_eq("rst_mem_en",      32'(mem_en), 0);
    rst_n = 1;
    step();

    // 1: single core read
    core_rd(32'h10);
    #1;
    check_eq("t1_core_gnt", 32'(core_gnt), 1);
    check_eq("t1_dbg_gnt",  32'(dbg_gnt), 0);
    check_eq("t1_mem_addr", mem_addr, 32'h10);
    step();
    idle();
    check_eq("t1_core_rvalid", 32'(core_rvalid), 1);
    check_eq("t1_core_rdata",  core_rdata, 32'hDEADBEEF);
    check_eq("t1_dbg_rvalid",  32'(dbg_rvalid), 0);
    step();
    check_eq("t1_rvalid_drop", 32'(core_rvalid), 0);
    check_eq("t1_rdata_hold",  core_rdata, 32'hDEADBEEF);

    // 2: sustained contention, STARVE_MAX=8 gives 8 core grants then 1 debug grant
    core_rd(32'h10);
    dbg_rd(32'h0);
    for (int i = 0; i < 20; i++) begin
      #1;
      check_eq("t2_core_gnt", 32'(core_gnt), ((i % 9) == 8) ? 0 : 1);
      check_eq("t2_dbg_gnt",  32'(dbg_gnt),  ((i % 9) == 8) ? 1 : 0);
      check_eq("t2_one_gnt",  32'(core_gnt & dbg_gnt), 0);
      step();
    end
    idle();
    step();

    // 3: lock requested while core is requesting
    core_rd(32'h10);
    dbg_lock = 1;
    #1;
    check_eq("t3_core_first", 32'(core_gnt), 1);
    check_eq("t3_owned_pre",  32'(dbg_owned), 0);
    step();
    idle();
    #1;
    check_eq("t3_no_core_gnt", 32'(core_gnt), 0);
    step();
    core_rd(32'h40);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t3_owned",       32'(dbg_owned), 1);
      check_eq("t3_core_locked", 32'(core_gnt), 0);
      check_eq("t3_mem_en_idle", 32'(mem_en), 0);
      step();
    end

    // 4: debug writes under lock, then core reads back
    dbg_wr(32'h40, 32'h12345678, 4'b1111);
    #1;
    check_eq("t4_dbg_gnt",  32'(dbg_gnt), 1);
    check_eq("t4_core_gnt", 32'(core_gnt), 0);
    check_eq("t4_mem_we",   32'(mem_we), 1);
    check_eq("t4_mem_wdata", mem_wdata, 32'h12345678);
    step();
    dbg_req = 0; dbg_we = 0;
    dbg_lock = 0;
    #1;
    check_eq("t4_still_owned", 32'(dbg_owned), 1);
    check_eq("t4_core_wait",   32'(core_gnt), 0);
    step();
    #1;
    check_eq("t4_unlock_gnt", 32'(core_gnt), 1);
    check_eq("t4_unowned",    32'(dbg_owned), 0);
    step();
    idle();
    check_eq("t4_rd_full", core_rdata, 32'h12345678);
    dbg_wr(32'h40, 32'h0000AB00, 4'b0010);
    step();
    idle();
    core_rd(32'h40);
    step();
    idle();
    check_eq("t4_rd_byte", core_rdata, 32'h1234AB78);
    check_eq("t4_rvalid",  32'(core_rvalid), 1);
    step();

    // 5a: reset clears the starvation counter and discards an in-reset read
    core_rd(32'h10);
    dbg_rd(32'h0);
    step(); step(); step();
    check_eq("t5_starve3", 32'(dut.starve_cnt_q), 3);
    rst_n = 0;
    step();
    rst_n = 1;
    idle();
    check_eq("t5_starve_rst", 32'(dut.starve_cnt_q), 0);
    check_eq("t5_core_rvalid", 32'(core_rvalid), 0);
    check_eq("t5_dbg_rvalid0", 32'(dbg_rvalid), 0);

    // 5b: reset the cycle after a granted debug read in LOCK
    dbg_lock = 1;
    step();
    dbg_rd(32'h40);
    #1;
    check_eq("t5_dbg_gnt", 32'(dbg_gnt), 1);
    step();
    idle();
    rst_n = 0;
    check_eq("t5_pre_rvalid", 32'(dbg_rvalid), 1);
    step();
    check_eq("t5_dbg_rvalid", 32'(dbg_rvalid), 0);
    check_eq("t5_state",      32'(dut.state_q), 32'(ARB));
    check_eq("t5_owned",      32'(dbg_owned), 0);
    check_eq("t5_dbg_rdata",  dbg_rdata, 0);
    dbg_lock = 0;
    rst_n = 1;
    step();

    // 6: alternating core/debug reads, returns steered to the right owner
    for (int i = 0; i < 6; i++) begin
      idle();
      if ((i % 2) == 0) core_rd(32'h20 + 4 * i);
      else              dbg_rd(32'h20 + 4 * i);
      step();
      if ((i % 2) == 0) begin
        check_eq("t6_core_rvalid", 32'(core_rvalid), 1);
        check_eq("t6_dbg_rvalid",  32'(dbg_rvalid), 0);
        check_eq("t6_core_rdata",  core_rdata, 32'hA000_0000 + i);
        if (i > 0) check_eq("t6_dbg_hold", dbg_rdata, 32'hA000_0000 + i - 1);
      end else begin
        check_eq("t6_dbg_rvalid",  32'(dbg_rvalid), 1);
        check_eq("t6_core_rvalid", 32'(core_rvalid), 0);
        check_eq("t6_dbg_rdata",   dbg_rdata, 32'hA000_0000 + i);
        check_eq("t6_core_hold",   core_rdata, 32'hA000_0000 + i - 1);
      end
    end
    idle();
    step();
    check_eq("t6_quiet", 32'(core_rvalid | dbg_rvalid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
`default_nettype wire
